// File: rtl/clint_icb_arb_pkg.sv
// -----------------------------------------------------------------------------
// clint_icb_arb_pkg
//   Shared constants for the CLINT ICB arbiter and its ID FIFO:
//   default ICB address/data widths and the master-ID encodings that are
//   carried through the outstanding-transaction FIFO.
// -----------------------------------------------------------------------------
package clint_icb_arb_pkg;

    localparam int MYRISCV_ADDRDW = 32;
    localparam int MYRISCV_XLEN   = 32;

    // Master IDs stored in the ID FIFO to steer each response back home.
    localparam logic CLINT_ARB_M0 = 1'b0;
    localparam logic CLINT_ARB_M1 = 1'b1;

endpackage

// File: rtl/icb_id_fifo.sv
// -----------------------------------------------------------------------------
// icb_id_fifo
//   Small synchronous FIFO that records which master issued each outstanding
//   ICB command. Depth 1 collapses to a register plus a valid bit; deeper
//   configurations (powers of two) use wrapping read/write pointers and a count.
//
// Ports
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset (control state only)
//   push_i       in   write push_data_i (ignored when full)
//   push_data_i  in   WIDTH bits of data to enqueue
//   pop_i        in   drop the head entry (ignored when empty)
//   full_o       out  no free entries, derived purely from registered state
//   empty_o      out  no entries, derived purely from registered state
//   head_o       out  oldest entry
// -----------------------------------------------------------------------------
module icb_id_fifo #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    generate
        if (DEPTH == 1) begin : g_single
            logic             vld_q;
            logic             vld_d;
            logic [WIDTH-1:0] data_q;

            // With one entry, push is only possible when empty, so push and
            // pop never coincide.
            always_comb begin
                vld_d = vld_q;
                if (push_i && !vld_q) begin
                    vld_d = 1'b1;
                end else if (pop_i && vld_q) begin
                    vld_d = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= 1'b0;
                end else begin
                    vld_q <= vld_d;
                end
            end

            always_ff @(posedge clk) begin
                if (push_i && !vld_q) begin
                    data_q <= push_data_i;
                end
            end

            assign full_o  = vld_q;
            assign empty_o = ~vld_q;
            assign head_o  = data_q;
        end else begin : g_multi
            localparam int PW = $clog2(DEPTH);

            logic [WIDTH-1:0] mem_q [DEPTH];
            logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
            logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
            logic [PW:0]      count_q, count_d;
            logic             push_ok;
            logic             pop_ok;

            assign full_o  = (count_q == (PW+1)'(DEPTH));
            assign empty_o = (count_q == '0);
            assign push_ok = push_i & ~full_o;
            assign pop_ok  = pop_i & ~empty_o;
            assign head_o  = mem_q[rd_ptr_q];

            // Pointers are exactly log2(DEPTH) bits, so +1 wraps naturally.
            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                count_d  = count_q;
                if (push_ok) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
                if (pop_ok) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
                case ({push_ok, pop_ok})
                    2'b10:   count_d = count_q + 1'b1;
                    2'b01:   count_d = count_q - 1'b1;
                    default: count_d = count_q;
                endcase
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    count_q  <= count_d;
                end
            end

            always_ff @(posedge clk) begin
                if (push_ok) begin
                    mem_q[wr_ptr_q] <= push_data_i;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/clint_icb_arb.sv
// -----------------------------------------------------------------------------
// clint_icb_arb
//   Two-master ICB arbiter in front of the CLINT register port. Master 0 is
//   the core LSU, master 1 the debug/system bus. Commands are granted
//   round-robin and passed through combinationally; the issuing master ID is
//   queued so responses (also combinational) return to the right master.
//
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   m0_icb_cmd_*          master 0 command (valid/ready/addr/read/wdata/wmask/size)
//   m0_icb_rsp_*          master 0 response (valid/ready/err/rdata)
//   m1_icb_cmd_*, m1_icb_rsp_*   same set for master 1
//   s_icb_cmd_*           command to clint; burst/beat/lock/excl tied to 0
//   s_icb_rsp_*           response from clint; excl_ok is unused
// -----------------------------------------------------------------------------
module clint_icb_arb
    import clint_icb_arb_pkg::*;
#(
    parameter int AW   = MYRISCV_ADDRDW,
    parameter int DW   = MYRISCV_XLEN,
    parameter int OSTD = 1
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            m0_icb_cmd_valid,
    output logic            m0_icb_cmd_ready,
    input  logic [AW-1:0]   m0_icb_cmd_addr,
    input  logic            m0_icb_cmd_read,
    input  logic [DW-1:0]   m0_icb_cmd_wdata,
    input  logic [DW/8-1:0] m0_icb_cmd_wmask,
    input  logic [1:0]      m0_icb_cmd_size,
    output logic            m0_icb_rsp_valid,
    input  logic            m0_icb_rsp_ready,
    output logic            m0_icb_rsp_err,
    output logic [DW-1:0]   m0_icb_rsp_rdata,

    input  logic            m1_icb_cmd_valid,
    output logic            m1_icb_cmd_ready,
    input  logic [AW-1:0]   m1_icb_cmd_addr,
    input  logic            m1_icb_cmd_read,
    input  logic [DW-1:0]   m1_icb_cmd_wdata,
    input  logic [DW/8-1:0] m1_icb_cmd_wmask,
    input  logic [1:0]      m1_icb_cmd_size,
    output logic            m1_icb_rsp_valid,
    input  logic            m1_icb_rsp_ready,
    output logic            m1_icb_rsp_err,
    output logic [DW-1:0]   m1_icb_rsp_rdata,

    output logic            s_icb_cmd_valid,
    input  logic            s_icb_cmd_ready,
    output logic [AW-1:0]   s_icb_cmd_addr,
    output logic            s_icb_cmd_read,
    output logic [DW-1:0]   s_icb_cmd_wdata,
    output logic [DW/8-1:0] s_icb_cmd_wmask,
    output logic [1:0]      s_icb_cmd_size,
    output logic [1:0]      s_icb_cmd_burst,
    output logic [1:0]      s_icb_cmd_beat,
    output logic            s_icb_cmd_lock,
    output logic            s_icb_cmd_excl,
    input  logic            s_icb_rsp_valid,
    output logic            s_icb_rsp_ready,
    input  logic            s_icb_rsp_err,
    input  logic [DW-1:0]   s_icb_rsp_rdata,
    input  logic            s_icb_rsp_excl_ok
);

    logic last_gnt_q, last_gnt_d;
    logic hold_vld_q, hold_vld_d;
    logic hold_id_q,  hold_id_d;

    logic gnt_id;
    logic gnt_valid;
    logic cmd_fire;
    logic rsp_fire;
    logic head_rdy;

    logic fifo_full;
    logic fifo_empty;
    logic fifo_head;

    logic unused_excl_ok;
    assign unused_excl_ok = s_icb_rsp_excl_ok;

    // Grant selection: a pending (stalled) command keeps its grant so the
    // downstream sees stable valid/payload; otherwise round-robin on ties.
    always_comb begin
        gnt_id = CLINT_ARB_M0;
        if (hold_vld_q) begin
            gnt_id = hold_id_q;
        end else if (m0_icb_cmd_valid && m1_icb_cmd_valid) begin
            gnt_id = ~last_gnt_q;
        end else if (m1_icb_cmd_valid) begin
            gnt_id = CLINT_ARB_M1;
        end
    end

    assign gnt_valid = (gnt_id == CLINT_ARB_M1) ? m1_icb_cmd_valid : m0_icb_cmd_valid;

    // fifo_full comes from registers only, so a same-cycle pop cannot open
    // the command path (no rsp->cmd combinational loop).
    assign s_icb_cmd_valid  = gnt_valid & ~fifo_full;
    assign cmd_fire         = s_icb_cmd_valid & s_icb_cmd_ready;
    assign m0_icb_cmd_ready = gnt_valid & (gnt_id == CLINT_ARB_M0) & s_icb_cmd_ready & ~fifo_full;
    assign m1_icb_cmd_ready = gnt_valid & (gnt_id == CLINT_ARB_M1) & s_icb_cmd_ready & ~fifo_full;

    assign s_icb_cmd_addr  = (gnt_id == CLINT_ARB_M1) ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
    assign s_icb_cmd_read  = (gnt_id == CLINT_ARB_M1) ? m1_icb_cmd_read  : m0_icb_cmd_read;
    assign s_icb_cmd_wdata = (gnt_id == CLINT_ARB_M1) ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
    assign s_icb_cmd_wmask = (gnt_id == CLINT_ARB_M1) ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;
    assign s_icb_cmd_size  = (gnt_id == CLINT_ARB_M1) ? m1_icb_cmd_size  : m0_icb_cmd_size;
    assign s_icb_cmd_burst = 2'b00;
    assign s_icb_cmd_beat  = 2'b00;
    assign s_icb_cmd_lock  = 1'b0;
    assign s_icb_cmd_excl  = 1'b0;

    // Response steering by FIFO head; a response with nothing outstanding is
    // neither accepted nor forwarded.
    assign head_rdy         = (fifo_head == CLINT_ARB_M1) ? m1_icb_rsp_ready : m0_icb_rsp_ready;
    assign s_icb_rsp_ready  = head_rdy & ~fifo_empty;
    assign rsp_fire         = s_icb_rsp_valid & s_icb_rsp_ready;
    assign m0_icb_rsp_valid = s_icb_rsp_valid & ~fifo_empty & (fifo_head == CLINT_ARB_M0);
    assign m1_icb_rsp_valid = s_icb_rsp_valid & ~fifo_empty & (fifo_head == CLINT_ARB_M1);
    assign m0_icb_rsp_err   = s_icb_rsp_err;
    assign m1_icb_rsp_err   = s_icb_rsp_err;
    assign m0_icb_rsp_rdata = s_icb_rsp_rdata;
    assign m1_icb_rsp_rdata = s_icb_rsp_rdata;

    always_comb begin
        last_gnt_d = last_gnt_q;
        hold_vld_d = hold_vld_q;
        hold_id_d  = hold_id_q;
        if (cmd_fire) begin
            last_gnt_d = gnt_id;
            hold_vld_d = 1'b0;
        end else if (s_icb_cmd_valid) begin
            hold_vld_d = 1'b1;
            hold_id_d  = gnt_id;
        end
    end

    // last_gnt resets to M1 so master 0 wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_gnt_q <= CLINT_ARB_M1;
            hold_vld_q <= 1'b0;
            hold_id_q  <= CLINT_ARB_M0;
        end else begin
            last_gnt_q <= last_gnt_d;
            hold_vld_q <= hold_vld_d;
            hold_id_q  <= hold_id_d;
        end
    end

    icb_id_fifo #(
        .DEPTH (OSTD),
        .WIDTH (1)
    ) u_id_fifo (
        .clk         (clk),
        .rst_n       (rst),
        .push_i      (cmd_fire),
        .push_data_i (gnt_id),
        .pop_i       (rsp_fire),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (fifo_head)
    );

    // Protocol check: clint must never respond with nothing outstanding.
    always_ff @(posedge clk) begin
        if (rst && s_icb_rsp_valid) begin
            assert (!fifo_empty)
                else $warning("clint_icb_arb: response with no outstanding command");
        end
    end

endmodule
